// File: rtl/mem_access_ctrl.sv
// Load/store front-end for a single-port data SRAM: issues a held chip-select
// access per CPU request and returns an aligned, extended load result or write ack.
module mem_access_ctrl #(
    parameter int AWIDTH  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              REQ,
    input  logic              REQ_WE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNSIGNED,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              REQ_ACK,
    output logic              RESP_VALID,
    output logic              RESP_ERR,
    output logic [31:0]       RESP_RDATA,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [AWIDTH-1:0] MEM_ADDR,
    output logic [3:0]        MEM_BE,
    output logic [31:0]       MEM_DI,
    input  logic [31:0]       MEM_DOUT,
    input  logic              MEM_READY,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        lat_we;
    logic        lat_uns;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;

    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] di_next;
    logic [31:0] shifted;
    logic [31:0] extracted;
    logic        unused_addr;

    assign unused_addr = ^REQ_ADDR[31:AWIDTH+2];
    assign REQ_ACK     = (state == IDLE) || (state == RESP);
    assign dbg_state   = state;

    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        di_next    = REQ_WDATA;
        case (REQ_SIZE)
            2'b00: begin
                be_next = 4'b0001 << REQ_ADDR[1:0];
                di_next = {4{REQ_WDATA[7:0]}};
            end
            2'b01: begin
                misaligned = REQ_ADDR[0];
                be_next    = REQ_ADDR[1] ? 4'b1100 : 4'b0011;
                di_next    = {2{REQ_WDATA[15:0]}};
            end
            default: begin
                misaligned = |REQ_ADDR[1:0];
            end
        endcase
    end

    // MEM_DOUT stays stable during RESP because CSN is already high, so the
    // load result can be taken straight from the SRAM output.
    always_comb begin
        shifted   = MEM_DOUT >> {lat_off, 3'b000};
        extracted = shifted;
        case (lat_size)
            2'b00:   extracted = lat_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   extracted = lat_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: extracted = shifted;
        endcase
        RESP_RDATA = 32'd0;
        if (state == RESP && !RESP_ERR && !lat_we) begin
            RESP_RDATA = extracted;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            lat_we     <= 1'b0;
            lat_uns    <= 1'b0;
            lat_size   <= 2'b00;
            lat_off    <= 2'b00;
            RESP_VALID <= 1'b0;
            RESP_ERR   <= 1'b0;
            MEM_CSN    <= 1'b1;
            MEM_WEN    <= 1'b1;
            MEM_ADDR   <= '0;
            MEM_BE     <= 4'd0;
            MEM_DI     <= 32'd0;
        end else begin
            RESP_VALID <= 1'b0;
            RESP_ERR   <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (REQ) begin
                        lat_we   <= REQ_WE;
                        lat_uns  <= REQ_UNSIGNED;
                        lat_size <= REQ_SIZE;
                        lat_off  <= REQ_ADDR[1:0];
                        if (misaligned) begin
                            state      <= RESP;
                            RESP_VALID <= 1'b1;
                            RESP_ERR   <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                            wait_cnt <= 8'd0;
                            MEM_CSN  <= 1'b0;
                            MEM_WEN  <= ~REQ_WE;
                            MEM_ADDR <= REQ_ADDR[AWIDTH+1:2];
                            MEM_BE   <= be_next;
                            MEM_DI   <= di_next;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (MEM_READY) begin
                        state      <= RESP;
                        MEM_CSN    <= 1'b1;
                        RESP_VALID <= 1'b1;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        // A timed-out store may already be committed; still an error.
                        state      <= RESP;
                        MEM_CSN    <= 1'b1;
                        RESP_VALID <= 1'b1;
                        RESP_ERR   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    MEM_CSN <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store front-end that sits directly upstream of the latency-configurable single-port data SRAM. It turns a CPU data request (byte/half/word, signed/unsigned, byte address) into a held chip-select transaction on the SRAM port and waits for `MEM_READY`. It then returns aligned, extended read data or a write acknowledge as a one-cycle response pulse. Misaligned accesses and a missing `MEM_READY` (watchdog timeout) are reported as errors.

## Interface
- `AWIDTH`, 12: SRAM word-address width.
- `TIMEOUT`, 16: maximum ACCESS cycles before abort; legal range 8..255.

- `CLK`  in  1: clock, all state on rising edge.
- `RSTn`  in  1: asynchronous, active-low reset.
- `REQ`  in  1: request valid.
- `REQ_WE`  in  1: 1 = store, 0 = load.
- `REQ_SIZE`  in  2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `REQ_UNSIGNED`  in  1: load zero-extends when 1, sign-extends when 0.
- `REQ_ADDR`  in  32: byte address.
- `REQ_WDATA`  in  32: store data, right-justified.
- `REQ_ACK`  out  1: request accepted at this edge if `REQ`=1.
- `RESP_VALID`  out  1: one-cycle response pulse.
- `RESP_ERR`  out  1: response is an error (misalign/timeout); valid with `RESP_VALID`.
- `RESP_RDATA`  out  32: load result; 0 for stores and errors.
- `MEM_CSN`  out  1: SRAM chip select, active low.
- `MEM_WEN`  out  1: 1 = read, 0 = write.
- `MEM_ADDR`  out  AWIDTH: word address = `REQ_ADDR[AWIDTH+1:2]`.
- `MEM_BE`  out  4: byte enables.
- `MEM_DI`  out  32: lane-replicated write data.
- `MEM_DOUT`  in  32: SRAM read data.
- `MEM_READY`  in  1: SRAM completion, sampled in ACCESS.

## Operation
- States: IDLE, ACCESS, RESP. `REQ_ACK` = (IDLE or RESP).
- IDLE/RESP with `REQ`=1: latch the request.
  - If aligned, go to ACCESS.
  - If misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0), go to RESP with error flagged and no SRAM access.
- RESP with `REQ`=0: go to IDLE.
- ACCESS:
  - `MEM_CSN`=0, with ADDR/WEN/BE/DI held constant from the latched request.
  - Wait counter counts from 0.
  - `MEM_READY`=1 at an edge: go to RESP, ERR=0.
  - Otherwise, when the counter reaches `TIMEOUT-1`: go to RESP, ERR=1.
- Outside ACCESS: `MEM_CSN`=1. The other `MEM_*` outputs hold their last values.
- BE by size:
  - byte: `1<<addr[1:0]`
  - half: `addr[1]` ? 1100 : 0011
  - word: 1111
- DI by size:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Read extract:
  - Shift `MEM_DOUT` right by `addr[1:0]*8`.
  - Take 8/16/32 bits and sign- or zero-extend per `REQ_UNSIGNED`.
- `RESP_RDATA` is combinational from `MEM_DOUT` during RESP of a successful load (`MEM_DOUT` is stable because CSN is high). It is 0 in every other case.
- Store timeout: the SRAM may already have committed the write; it is still reported ERR=1.

## Timing
- Reset (async, immediate): state IDLE, `MEM_CSN`=1, `MEM_WEN`=1, `MEM_BE`=0, `MEM_ADDR`=0, `MEM_DI`=0, `RESP_VALID`=0, `RESP_ERR`=0, `RESP_RDATA`=0, `REQ_ACK`=1.
- Accept edge t0, SRAM latency L (1..7):
  - ACCESS spans cycles t0..t0+L-1.
  - `MEM_READY` is sampled high at edge t0+L.
  - RESP occupies cycle t0+L..t0+L+1.
- Misaligned request: RESP occupies the cycle immediately after the accept edge; `MEM_CSN` never falls.
- Timeout: ACCESS lasts exactly `TIMEOUT` cycles, then RESP with ERR=1.
- Back-to-back: a request accepted during RESP enters ACCESS at the next edge.
  - CSN is high for exactly one cycle between transactions, which resets the SRAM latency counter.
  - The old response still pulses normally.
- `REQ_*` inputs are ignored while in ACCESS.
- Reset asserted mid-ACCESS: CSN rises asynchronously, no response is produced, and the pending request is discarded.

## Test plan
- Aligned word load, L=3, addr 0x10, SRAM word 4 = 0x8899AABB -> CSN low for 3 cycles with `MEM_ADDR`=4, BE=1111, WEN=1; RESP_VALID at accept+3 with RDATA=0x8899AABB, ERR=0.
- Signed/unsigned byte loads of 0x8899AABB, addr 0x11, L=1 -> signed 0xFFFFFFAA, unsigned 0x000000AA; half signed at 0x12 -> 0xFFFF8899.
- Byte store 0x5A to 0x13, then word load of 0x10 -> BE=1000, DI=0x5A5A5A5A; readback 0x5A99AABB.
- Misaligned half at 0x21 and word at 0x22 -> CSN stays 1; RESP_VALID with ERR=1 and RDATA=0 one cycle after accept.
- LATENCY=0 (READY never asserts), TIMEOUT=16 -> CSN low exactly 16 cycles, then RESP ERR=1; the next request completes normally.
- Back-to-back loads with `REQ` held high, L=2 -> responses every 3 cycles and a one-cycle CSN gap. Asserting `RSTn`=0 mid-ACCESS drops CSN high immediately and produces no RESP_VALID.
